// File: rtl/ps_pkg.sv
// Shared program-sequencer package: stack sizing, bus-connect select codes
// and the push/pop command encoding used by the PC/status stack.
package ps_pkg;

    localparam int PS_STCK_DEPTH = 16;
    localparam int PS_STCK_DW    = 16;

    // Bus-connect data-input select code that routes the stack output word.
    localparam logic [1:0] PS_DI_SLCT_STCK = 2'b01;

    // Stack command as decoded from {push, pop}.
    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_POP  = 2'b01,
        CMD_PUSH = 2'b10,
        CMD_XCHG = 2'b11
    } ps_cmd_e;

endpackage : ps_pkg

// File: rtl/ps_stck_mem.sv
// Stack storage: DEPTH x DW register array, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module ps_stck_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write the addressed entry on a write-enable edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : ps_stck_mem

// File: rtl/ps_pc_stack.sv
// Program-sequencer PC/status stack. Holds pushed words, registers popped
// words onto ps_stck_dout one cycle after decode (aligned with the
// bus-connect select), and reports full/empty/sticky-error status.
module ps_pc_stack
    import ps_pkg::*;
#(
    parameter int DEPTH = PS_STCK_DEPTH,
    parameter int DW    = PS_STCK_DW,
    parameter int AW    = $clog2(DEPTH),
    parameter int SPW   = AW + 1
) (
    input  logic           clk_dcd,
    input  logic           rst_n,
    input  logic           ps_pshstck,
    input  logic           ps_popstck,
    input  logic [DW-1:0]  ps_stck_din,
    input  logic           ps_stck_clr,
    output logic [DW-1:0]  ps_stck_dout,
    output logic [DW-1:0]  ps_stck_top,
    output logic           ps_stck_empty,
    output logic           ps_stck_full,
    output logic           ps_stck_ovf,
    output logic           ps_stck_unf,
    output logic [SPW-1:0] ps_stck_lvl
);

    logic [SPW-1:0] sp_q, sp_d;
    logic [DW-1:0]  dout_q, dout_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;

    logic           memWe;
    logic [AW-1:0]  memWaddr;
    logic [AW-1:0]  memRaddr;
    logic [DW-1:0]  memRdata;
    logic [SPW-1:0] spMinus1;
    logic           isEmpty;
    logic           isFull;
    ps_cmd_e        cmd;

    assign cmd      = ps_cmd_e'({ps_pshstck, ps_popstck});
    assign spMinus1 = sp_q - SPW'(1);
    assign memRaddr = spMinus1[AW-1:0];
    assign isEmpty  = (sp_q == '0);
    assign isFull   = (sp_q == SPW'(DEPTH));

    ps_stck_mem #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_dcd),
        .we_i    (memWe),
        .waddr_i (memWaddr),
        .wdata_i (ps_stck_din),
        .raddr_i (memRaddr),
        .rdata_o (memRdata)
    );

    // Decode clr > exchange > push > pop into next pointer, flags, output word and write port.
    always_comb begin
        sp_d     = sp_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        memWe    = 1'b0;
        memWaddr = sp_q[AW-1:0];

        if (ps_stck_clr) begin
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            unique case (cmd)
                CMD_XCHG: begin
                    memWe = 1'b1;
                    if (isEmpty) begin
                        unf_d    = 1'b1;
                        dout_d   = '0;
                        memWaddr = '0;
                        sp_d     = SPW'(1);
                    end else begin
                        dout_d   = memRdata;
                        memWaddr = memRaddr;
                    end
                end
                CMD_PUSH: begin
                    if (isFull) begin
                        ovf_d = 1'b1;
                    end else begin
                        memWe = 1'b1;
                        sp_d  = sp_q + SPW'(1);
                    end
                end
                CMD_POP: begin
                    if (isEmpty) begin
                        unf_d  = 1'b1;
                        dout_d = '0;
                    end else begin
                        dout_d = memRdata;
                        sp_d   = spMinus1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointer, output word and sticky flags; reset aborts any pending command.
    always_ff @(posedge clk_dcd or negedge rst_n) begin
        if (!rst_n) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign ps_stck_dout  = dout_q;
    assign ps_stck_top   = isEmpty ? '0 : memRdata;
    assign ps_stck_empty = isEmpty;
    assign ps_stck_full  = isFull;
    assign ps_stck_ovf   = ovf_q;
    assign ps_stck_unf   = unf_q;
    assign ps_stck_lvl   = sp_q;

endmodule : ps_pc_stack

// File: tb/tb_ps_pc_stack.sv
// Directed testbench for ps_pc_stack with a model of the bus-connect select
// register to check that popped words line up with select code 01.
module tb_ps_pc_stack;
    import ps_pkg::*;

    localparam int DW  = 16;
    localparam int SPW = 5;

    logic           clk;
    logic           rst_n;
    logic           push;
    logic           pop;
    logic           clr;
    logic [DW-1:0]  din;
    logic [DW-1:0]  dout;
    logic [DW-1:0]  top;
    logic           empty;
    logic           full;
    logic           ovf;
    logic           unf;
    logic [SPW-1:0] lvl;
    logic [1:0]     bcSlct;

    int checks = 0;
    int errors = 0;

    ps_pc_stack dut (
        .clk_dcd       (clk),
        .rst_n         (rst_n),
        .ps_pshstck    (push),
        .ps_popstck    (pop),
        .ps_stck_din   (din),
        .ps_stck_clr   (clr),
        .ps_stck_dout  (dout),
        .ps_stck_top   (top),
        .ps_stck_empty (empty),
        .ps_stck_full  (full),
        .ps_stck_ovf   (ovf),
        .ps_stck_unf   (unf),
        .ps_stck_lvl   (lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-connect select control: registers the stack select one cycle after a decoded pop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcSlct <= 2'b00;
        else        bcSlct <= pop ? PS_DI_SLCT_STCK : 2'b00;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One decode cycle: drive request, clock it, sample 1 time unit after the edge.
    task automatic applyStimulus(input logic p, input logic q, input logic c, input logic [DW-1:0] d);
        push = p;
        pop  = q;
        clr  = c;
        din  = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        din  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        clr   = 1'b0;
        din   = '0;
        #12;
        checkOutput("rst_lvl",   32'(lvl),   32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full",  32'(full),  32'd0);
        checkOutput("rst_dout",  32'(dout),  32'h0);
        checkOutput("rst_top",   32'(top),   32'h0);
        checkOutput("rst_flags", 32'({ovf, unf}), 32'd0);
        #1 rst_n = 1'b1;

        // Push three, pop three in LIFO order
        applyStimulus(1, 0, 0, 16'h1111);
        applyStimulus(1, 0, 0, 16'h2222);
        applyStimulus(1, 0, 0, 16'h3333);
        checkOutput("pp_lvl3", 32'(lvl), 32'd3);
        checkOutput("pp_top3", 32'(top), 32'h3333);
        applyStimulus(0, 1, 0, '0);
        checkOutput("pp_dout1", 32'(dout), 32'h3333);
        checkOutput("pp_lvl2",  32'(lvl),  32'd2);
        applyStimulus(0, 1, 0, '0);
        checkOutput("pp_dout2", 32'(dout), 32'h2222);
        checkOutput("pp_lvl1",  32'(lvl),  32'd1);
        applyStimulus(0, 1, 0, '0);
        checkOutput("pp_dout3", 32'(dout), 32'h1111);
        checkOutput("pp_lvl0",  32'(lvl),  32'd0);
        checkOutput("pp_empty", 32'(empty), 32'd1);
        checkOutput("pp_flags", 32'({ovf, unf}), 32'd0);

        // Fill, overflow, pop
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, DW'(i));
            if (i == 14) checkOutput("full_at15", 32'(full), 32'd0);
        end
        checkOutput("full_at16", 32'(full), 32'd1);
        checkOutput("full_lvl",  32'(lvl),  32'd16);
        checkOutput("full_ovf0", 32'(ovf),  32'd0);
        applyStimulus(1, 0, 0, 16'hDEAD);
        checkOutput("ovf_set",   32'(ovf),  32'd1);
        checkOutput("ovf_lvl",   32'(lvl),  32'd16);
        checkOutput("ovf_top",   32'(top),  32'h000F);
        applyStimulus(0, 1, 0, '0);
        checkOutput("ovf_pop",   32'(dout), 32'h000F);
        checkOutput("ovf_lvl15", 32'(lvl),  32'd15);
        checkOutput("ovf_stick", 32'(ovf),  32'd1);
        applyStimulus(0, 0, 1, '0);
        checkOutput("clr_ovf",   32'(ovf),   32'd0);
        checkOutput("clr_empty", 32'(empty), 32'd1);
        checkOutput("clr_dout",  32'(dout),  32'h000F);

        // Underflow
        applyStimulus(0, 1, 0, '0);
        checkOutput("unf_set",  32'(unf),  32'd1);
        checkOutput("unf_dout", 32'(dout), 32'h0);
        checkOutput("unf_lvl",  32'(lvl),  32'd0);
        applyStimulus(1, 0, 0, 16'hABCD);
        checkOutput("unf_stick", 32'(unf), 32'd1);
        checkOutput("unf_top",   32'(top), 32'hABCD);
        applyStimulus(0, 0, 1, '0);
        checkOutput("unf_clr",   32'(unf),   32'd0);
        checkOutput("unf_empty", 32'(empty), 32'd1);
        checkOutput("clr_top",   32'(top),   32'h0);

        // Exchange, partial and full
        applyStimulus(1, 0, 0, 16'hAAAA);
        applyStimulus(1, 0, 0, 16'hBBBB);
        applyStimulus(1, 1, 0, 16'hCCCC);
        checkOutput("xchg_dout", 32'(dout), 32'hBBBB);
        checkOutput("xchg_top",  32'(top),  32'hCCCC);
        checkOutput("xchg_lvl",  32'(lvl),  32'd2);
        for (int i = 0; i < 14; i++) applyStimulus(1, 0, 0, DW'(16'h0100 + i));
        checkOutput("xfull_full", 32'(full), 32'd1);
        applyStimulus(1, 1, 0, 16'h5555);
        checkOutput("xfull_dout", 32'(dout), 32'h010D);
        checkOutput("xfull_top",  32'(top),  32'h5555);
        checkOutput("xfull_lvl",  32'(lvl),  32'd16);
        checkOutput("xfull_ovf",  32'(ovf),  32'd0);
        applyStimulus(0, 1, 0, '0);
        checkOutput("xfull_pop",  32'(dout), 32'h5555);
        applyStimulus(0, 1, 0, '0);
        checkOutput("xfull_pop2", 32'(dout), 32'h010C);

        // Exchange on empty stack: underflow plus push
        applyStimulus(0, 0, 1, '0);
        applyStimulus(1, 1, 0, 16'h7777);
        checkOutput("xemp_unf",  32'(unf),  32'd1);
        checkOutput("xemp_dout", 32'(dout), 32'h0);
        checkOutput("xemp_lvl",  32'(lvl),  32'd1);
        checkOutput("xemp_top",  32'(top),  32'h7777);

        // Alignment with bus-connect select
        applyStimulus(0, 0, 1, '0);
        applyStimulus(1, 0, 0, 16'h1234);
        applyStimulus(1, 0, 0, 16'h5678);
        checkOutput("bc_idle", 32'(bcSlct), 32'd0);
        applyStimulus(0, 1, 0, '0);
        checkOutput("bc_slct1", 32'(bcSlct), 32'(PS_DI_SLCT_STCK));
        checkOutput("bc_dout1", 32'(dout),   32'h5678);
        applyStimulus(0, 1, 0, '0);
        checkOutput("bc_slct2", 32'(bcSlct), 32'(PS_DI_SLCT_STCK));
        checkOutput("bc_dout2", 32'(dout),   32'h1234);
        applyStimulus(0, 0, 0, '0);
        checkOutput("bc_slct3", 32'(bcSlct), 32'd0);
        checkOutput("bc_hold",  32'(dout),   32'h1234);

        // Asynchronous reset mid-run with three entries held
        applyStimulus(1, 0, 0, 16'h0A0A);
        applyStimulus(1, 0, 0, 16'h0B0B);
        applyStimulus(1, 0, 0, 16'h0C0C);
        checkOutput("mrst_pre", 32'(lvl), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mrst_lvl",   32'(lvl),   32'd0);
        checkOutput("mrst_empty", 32'(empty), 32'd1);
        checkOutput("mrst_dout",  32'(dout),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 16'h9999);
        checkOutput("post_lvl", 32'(lvl), 32'd1);
        checkOutput("post_top", 32'(top), 32'h9999);
        checkOutput("post_unf", 32'(unf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ps_pc_stack

// File: doc/ps_pc_stack.md
# ps_pc_stack

Program-sequencer PC/status stack that feeds the bus-connect data-input path. It stores pushed words on `ps_pshstck` and, on `ps_popstck`, registers the popped word onto `ps_stck_dout`. The word appears in the cycle in which the bus-connect select control presents `ps_bc_di_slct = 2'b01` (registered one cycle after decode). It also reports full, empty and sticky error status to the sequencer's exception logic.

## Interface
- `DEPTH`, default 16: number of stack entries, power of two, at least 2.
- `DW`, default 16: stack word width.
- `clk_dcd`, input, 1: decode clock, shared with the bus-connect select control.
- `rst_n`, input, 1: asynchronous active-low reset.
- `ps_pshstck`, input, 1: push request, decoded this cycle.
- `ps_popstck`, input, 1: pop request, decoded this cycle.
- `ps_stck_din`, input, DW: push data, sampled at the same edge as `ps_pshstck`.
- `ps_stck_clr`, input, 1: synchronous flush; empties the stack and clears the error flags.
- `ps_stck_dout`, output, DW: registered popped word.
- `ps_stck_top`, output, DW: combinational current top-of-stack; 0 when empty.
- `ps_stck_empty`, output, 1: no entries held.
- `ps_stck_full`, output, 1: DEPTH entries held.
- `ps_stck_ovf`, output, 1: sticky overflow, set on a push while full.
- `ps_stck_unf`, output, 1: sticky underflow, set on a pop while empty.
- `ps_stck_lvl`, output, log2(DEPTH)+1: current entry count.

## Operation
- Storage is a DEPTH x DW register array with stack pointer `sp` of width log2(DEPTH)+1.
  - `sp` is the entry count. The top entry is `mem[sp-1]`.
- Command decode uses priority order clr, then push&pop, then push, then pop.
- **clr:** sets `sp` to 0 and clears ovf/unf. `ps_stck_dout` holds its value. Memory contents are don't-care.
- **push only, not full:** writes `mem[sp]` with `ps_stck_din` and increments `sp`.
- **push only, full:** sets ovf. The stack and `sp` are unchanged and the data is dropped.
- **pop only, not empty:** loads `ps_stck_dout` with `mem[sp-1]` and decrements `sp`.
- **pop only, empty:** sets unf. Loads `ps_stck_dout` with 0. `sp` stays 0.
- **push and pop together, not empty:** exchange.
  - `ps_stck_dout` is loaded with the old top.
  - `mem[sp-1]` is overwritten with `ps_stck_din`.
  - `sp` is unchanged.
  - No flag is set, even when full.
- **push and pop together, empty:** sets unf. Loads `ps_stck_dout` with 0, then performs the push (`sp` becomes 1).
- Status and level outputs:
  - `ps_stck_empty` is `(sp == 0)`.
  - `ps_stck_full` is `(sp == DEPTH)`.
  - `ps_stck_lvl` is `sp`.
  - All three are combinational from the registered `sp`.
- ovf and unf stay set until clr or reset. They never self-clear.
- No wrap-around: `sp` never exceeds DEPTH and never goes below 0.

## Timing
- All state updates on the posedge of `clk_dcd`.
- Reset (asynchronous, `rst_n` = 0) sets:
  - `sp` = 0
  - `ps_stck_dout` = 0
  - ovf = 0, unf = 0
  - so `ps_stck_empty` = 1, `ps_stck_full` = 0, `ps_stck_lvl` = 0, `ps_stck_top` = 0
- Memory is not reset.
- Pop latency: request at edge N produces the popped word on `ps_stck_dout` after edge N. It is stable for the whole of cycle N+1, aligned with `ps_bc_di_slct`. It holds until the next pop or exchange.
- Push latency: data written at edge N is visible on `ps_stck_top` in cycle N+1.
- Flags change one edge after the causing request.
- Reset asserted mid-operation aborts any pending command. The first edge after deassertion behaves as from empty.
- Back-to-back pops on consecutive cycles are supported at full rate. So are back-to-back pushes, and alternating push and pop.

## Structure
- The shared `ps_pkg` holds:
  - `PS_STCK_DEPTH`
  - `PS_STCK_DW`
  - the `PS_DI_SLCT_STCK = 2'b01` constant, shared with bus-connect select control
  - a 2-bit command encoding `{push, pop}`
- One sub-module, `ps_stck_mem`: DEPTH x DW register array with one synchronous write port and one asynchronous read port indexed by `sp-1`.
- Pointer, flag and output-register logic live in the top `ps_pc_stack`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run with 3 entries held. Required: `ps_stck_lvl` = 0, empty = 1, dout = 0 immediately, without waiting for a clock edge.
- **Push and pop:**
  - Stimulus: push 16'h1111, 16'h2222, 16'h3333, then pop 3 times.
  - Required: dout is 3333, 2222, 1111 on successive cycles after each pop edge.
  - Required: lvl reads 3, 2, 1, 0; empty = 1 at the end; no flags set.
- **Full and overflow:**
  - Stimulus: push 16 words 16'h0000..16'h000F, then a 17th word 16'hDEAD.
  - Required: full = 1 after the 16th push; ovf = 1 after the 17th; lvl stays 16.
  - Required: one subsequent pop returns 16'h000F.
- **Underflow:**
  - Stimulus: pop while empty.
  - Required: unf = 1, dout = 0, lvl = 0.
  - Stimulus: then push 16'hABCD.
  - Required: unf still 1, top = ABCD.
  - Stimulus: then clr.
  - Required: unf = 0, empty = 1.
- **Exchange:**
  - Stimulus: hold 2 entries (AAAA, BBBB), then push 16'hCCCC and pop in the same cycle.
  - Required: dout = BBBB, top = CCCC, lvl = 2.
  - Stimulus: repeat the exchange while full.
  - Required: ovf stays 0.
- **Alignment with bus-connect select:** drive the decode pop together with the bus-connect select control. Required: dout equals the popped word exactly in the cycle in which `ps_bc_di_slct` = 01.
